// File: rtl/clock_pkg.sv
// clock_pkg: shared mode encoding for the clock set controller
package clock_pkg;
    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2
    } clk_mode_t;
endpackage

// File: rtl/clock_blink_gen.sv
// clock_blink_gen: divides tick_fast into a blink phase that toggles every BLINK_TICKS pulses
module clock_blink_gen #(
    parameter int BLINK_TICKS = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic tick_fast,
    output logic phase
);
    localparam int BW = BLINK_TICKS > 1 ? $clog2(BLINK_TICKS) : 1;
    logic [BW-1:0] cnt;
    logic          wrap;
    assign wrap = cnt == BW'(BLINK_TICKS - 1);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (clr) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (en && tick_fast) begin
            cnt   <= wrap ? '0 : cnt + BW'(1);
            phase <= wrap ? ~phase : phase;
        end
    end
endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: run/set mode sequencer routing ticks, carries and button increments to the time counters
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int BLINK_TICKS = 5,
    parameter int TIMEOUT_S   = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       tick_fast,
    input  logic       sec_rollover,
    input  logic       min_rollover,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic       sec_inc,
    output logic       min_inc,
    output logic       hour_inc,
    output logic       sec_clr,
    output logic [1:0] mode,
    output logic       blink_hours,
    output logic       blink_min
);
    localparam int TW = $clog2(TIMEOUT_S + 1);
    clk_mode_t     state;
    logic [TW-1:0] tcnt;
    logic          in_set, timeout, chg, phase, inc;
    assign in_set  = state != MODE_RUN;
    assign inc     = btn_inc && !btn_mode;
    // button activity in the same cycle restarts the idle count instead of expiring it
    assign timeout = in_set && !btn_mode && !btn_inc && tick_1hz && tcnt == TW'(TIMEOUT_S - 1);
    assign chg     = btn_mode || timeout;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= MODE_RUN;
            tcnt     <= '0;
            sec_inc  <= 1'b0;
            min_inc  <= 1'b0;
            hour_inc <= 1'b0;
            sec_clr  <= 1'b0;
        end else begin
            sec_inc  <= state == MODE_RUN && tick_1hz;
            min_inc  <= state == MODE_RUN ? sec_rollover : state == MODE_SET_MIN && inc;
            hour_inc <= state == MODE_RUN ? min_rollover : state == MODE_SET_HOUR && inc;
            sec_clr  <= (btn_mode && state == MODE_SET_MIN) || timeout;
            state    <= timeout   ? MODE_RUN :
                        !btn_mode ? state :
                        state == MODE_RUN      ? MODE_SET_HOUR :
                        state == MODE_SET_HOUR ? MODE_SET_MIN : MODE_RUN;
            tcnt     <= (!in_set || chg || btn_inc) ? '0 : tcnt + TW'(tick_1hz);
        end
    end
    clock_blink_gen #(.BLINK_TICKS(BLINK_TICKS)) u_blink (
        .clk       (clk),
        .rst       (rst),
        .clr       (chg),
        .en        (in_set),
        .tick_fast (tick_fast),
        .phase     (phase)
    );
    assign mode        = state;
    assign blink_hours = phase && state == MODE_SET_HOUR;
    assign blink_min   = phase && state == MODE_SET_MIN;
endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: directed vectors with a queue-based scoreboard for clock_set_ctrl
module tb_clock_set_ctrl;
    localparam logic [5:0] BM = 6'b100000, BI = 6'b010000, T1 = 6'b001000;
    localparam logic [5:0] TF = 6'b000100, SR = 6'b000010, MR = 6'b000001;
    logic clk = 1'b0, rst = 1'b0;
    logic tick_1hz = 0, tick_fast = 0, sec_rollover = 0, min_rollover = 0, btn_mode = 0, btn_inc = 0;
    logic sec_inc, min_inc, hour_inc, sec_clr, blink_hours, blink_min;
    logic [1:0] mode;
    logic [7:0] got;
    int cyc = 0, checks = 0, failures = 0;
    typedef struct {
        int         cyc;
        logic [7:0] exp;
        string      name;
    } item_t;
    item_t q[$];

    clock_set_ctrl dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_fast(tick_fast),
        .sec_rollover(sec_rollover), .min_rollover(min_rollover),
        .btn_mode(btn_mode), .btn_inc(btn_inc),
        .sec_inc(sec_inc), .min_inc(min_inc), .hour_inc(hour_inc), .sec_clr(sec_clr),
        .mode(mode), .blink_hours(blink_hours), .blink_min(blink_min)
    );

    assign got = {sec_inc, min_inc, hour_inc, sec_clr, mode, blink_hours, blink_min};
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] e(input logic s, m, h, c, input logic [1:0] md, input logic bh, bn);
        return {s, m, h, c, md, bh, bn};
    endfunction

    task automatic step(input logic [5:0] in, input logic [7:0] exp, input string name);
        @(posedge clk);
        #1;
        {btn_mode, btn_inc, tick_1hz, tick_fast, sec_rollover, min_rollover} = in;
        q.push_back('{cyc + 1, exp, name});
    endtask

    task automatic chk(input string name, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got={s,m,h,clr,mode,bh,bm}=%b exp=%b", name, got, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        item_t it;
        if (q.size() > 0 && q[0].cyc <= cyc) begin
            it = q.pop_front();
            checks++;
            if (it.cyc != cyc || got !== it.exp) begin
                failures++;
                $display("FAIL %s cyc=%0d/%0d got={s,m,h,clr,mode,bh,bm}=%b exp=%b",
                         it.name, cyc, it.cyc, got, it.exp);
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 chk("reset_state", 8'd0);
        @(negedge clk) rst = 1'b1;
        step(T1 | SR, e(1, 1, 0, 0, 0, 0, 0), "run_tick_and_roll");
        step(MR,      e(0, 0, 1, 0, 0, 0, 0), "run_min_carry");
        step(BI | TF, e(0, 0, 0, 0, 0, 0, 0), "run_inc_ignored");
        step(BM,      e(0, 0, 0, 0, 1, 0, 0), "enter_set_hour");
        repeat (3) begin
            step(BI, e(0, 0, 1, 0, 1, 0, 0), "set_hour_inc");
            step(0,  e(0, 0, 0, 0, 1, 0, 0), "set_hour_idle");
        end
        step(BI | T1,      e(0, 0, 1, 0, 1, 0, 0), "set_hour_inc_tick_blocked");
        step(SR | MR | T1, e(0, 0, 0, 0, 1, 0, 0), "set_hour_rollovers_ignored");
        step(BM | BI,      e(0, 0, 0, 0, 2, 0, 0), "mode_beats_inc");
        step(BI | MR,      e(0, 1, 0, 0, 2, 0, 0), "set_min_inc_no_carry");
        step(SR | T1,      e(0, 0, 0, 0, 2, 0, 0), "set_min_tick_blocked");
        step(BM,           e(0, 0, 0, 1, 0, 0, 0), "leave_set_min_clr");
        step(0,            e(0, 0, 0, 0, 0, 0, 0), "clr_single_cycle");
        step(BM, e(0, 0, 0, 0, 1, 0, 0), "timeout_enter");
        for (int i = 1; i <= 29; i++) step(T1, e(0, 0, 0, 0, 1, 0, 0), "timeout_wait_a");
        step(BI, e(0, 0, 1, 0, 1, 0, 0), "timeout_btn_restart");
        for (int i = 1; i <= 29; i++) step(T1, e(0, 0, 0, 0, 1, 0, 0), "timeout_wait_b");
        step(T1, e(0, 0, 0, 1, 0, 0, 0), "timeout_fire");
        step(0,  e(0, 0, 0, 0, 0, 0, 0), "timeout_after");
        step(BM, e(0, 0, 0, 0, 1, 0, 0), "blink_enter_hour");
        step(BM, e(0, 0, 0, 0, 2, 0, 0), "blink_enter_min");
        for (int i = 1; i <= 12; i++)
            step(TF, e(0, 0, 0, 0, 2, 0, logic'((i / 5) % 2)), "blink_min_phase");
        step(BM, e(0, 0, 0, 1, 0, 0, 0), "blink_exit_run");
        step(TF, e(0, 0, 0, 0, 0, 0, 0), "run_no_blink");
        step(BM, e(0, 0, 0, 0, 1, 0, 0), "blink_hour_enter");
        for (int i = 1; i <= 5; i++)
            step(TF, e(0, 0, 0, 0, 1, logic'(i == 5), 0), "blink_hours_phase");
        step(BM, e(0, 0, 0, 0, 2, 0, 0), "phase_reset_on_entry");
        step(TF | BI, e(0, 1, 0, 0, 2, 0, 0), "pre_reset_inc");
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1 chk("async_reset_mid", 8'd0);
        {btn_mode, btn_inc, tick_1hz, tick_fast, sec_rollover, min_rollover} = 6'd0;
        @(negedge clk) rst = 1'b1;
        step(0,  e(0, 0, 0, 0, 0, 0, 0), "post_reset_idle");
        step(T1, e(1, 0, 0, 0, 0, 0, 0), "post_reset_run_tick");
        step(0,  e(0, 0, 0, 0, 0, 0, 0), "post_reset_quiet");
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
